// File: rtl/snn_spike_classifier.sv
// Spike-count classifier: accumulates per-neuron output spikes, then scans for the argmax.
// Optional result-ready interrupt enabled by defining SNN_CLASSIFIER_IRQ_EN.
module snn_spike_classifier #(
  parameter int NUM_OUT = 10,
  parameter int CNT_W   = 8,
  parameter int IDX_W   = 4
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               start_i,
  input  logic               step_valid_i,
  input  logic               last_step_i,
  input  logic [NUM_OUT-1:0] spike_vec_i,
  input  logic [IDX_W-1:0]   cnt_sel_i,
  output logic [CNT_W-1:0]   cnt_o,
  output logic               busy_o,
  output logic               result_valid_o,
  output logic [IDX_W-1:0]   class_o,
  output logic [CNT_W-1:0]   max_count_o,
  output logic               irq_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_SCAN  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int SCAN_W = $clog2(NUM_OUT + 1);
  localparam logic [SCAN_W-1:0] SCAN_END = SCAN_W'(NUM_OUT);

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt [NUM_OUT];
  logic [SCAN_W-1:0] r_scan_idx;
  logic [IDX_W-1:0]  r_best_idx;
  logic [CNT_W-1:0]  r_best_cnt;
  logic [CNT_W-1:0]  w_scan_cnt;
  logic [CNT_W-1:0]  w_sel_cnt;
  logic              w_scan_end;

  // Explicit compare-mux keeps out-of-range selects at zero without array bound issues
  always_comb begin
    w_scan_cnt = '0;
    w_sel_cnt  = '0;
    for (int unsigned k = 0; k < NUM_OUT; k++) begin
      if (r_scan_idx == SCAN_W'(k)) w_scan_cnt = r_cnt[k];
      if (cnt_sel_i == IDX_W'(k))   w_sel_cnt  = r_cnt[k];
    end
  end

  assign w_scan_end = (r_scan_idx == SCAN_END);

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      for (int unsigned k = 0; k < NUM_OUT; k++) r_cnt[k] <= '0;
    end else if (start_i) begin
      for (int unsigned k = 0; k < NUM_OUT; k++) r_cnt[k] <= '0;
    end else if (r_state == S_ACCUM && step_valid_i) begin
      for (int unsigned k = 0; k < NUM_OUT; k++)
        if (spike_vec_i[k] && r_cnt[k] != '1) r_cnt[k] <= r_cnt[k] + 1'b1;
    end
  end

  // SCAN spends one extra cycle at index NUM_OUT so DONE lands NUM_OUT+1 edges after the last step
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_state    <= S_IDLE;
      r_scan_idx <= '0;
      r_best_idx <= '0;
      r_best_cnt <= '0;
    end else if (start_i) begin
      r_state    <= S_ACCUM;
      r_scan_idx <= '0;
      r_best_idx <= '0;
      r_best_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: ;
        S_ACCUM: begin
          if (step_valid_i && last_step_i) begin
            r_state    <= S_SCAN;
            r_scan_idx <= '0;
          end
        end
        S_SCAN: begin
          if (w_scan_end) begin
            r_state <= S_DONE;
          end else begin
            if (w_scan_cnt > r_best_cnt) begin
              r_best_idx <= IDX_W'(r_scan_idx);
              r_best_cnt <= w_scan_cnt;
            end
            r_scan_idx <= r_scan_idx + 1'b1;
          end
        end
        S_DONE: ;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef SNN_CLASSIFIER_IRQ_EN
  logic r_irq;
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) r_irq <= 1'b0;
    else           r_irq <= (r_state == S_SCAN) && w_scan_end && !start_i;
  end
  assign irq_o = r_irq;
`else
  assign irq_o = 1'b0;
`endif

  assign cnt_o          = w_sel_cnt;
  assign busy_o         = (r_state == S_ACCUM) || (r_state == S_SCAN);
  assign result_valid_o = (r_state == S_DONE);
  assign class_o        = r_best_idx;
  assign max_count_o    = r_best_cnt;

endmodule

// File: tb/tb_snn_spike_classifier.sv
// Self-checking bench for snn_spike_classifier: behavioural count/argmax model plus directed scenarios.
module tb_snn_spike_classifier;

  localparam int NUM_OUT = 10;
  localparam int CNT_W   = 8;
  localparam int IDX_W   = 4;
  localparam int CMAX    = (1 << CNT_W) - 1;
`ifdef SNN_CLASSIFIER_IRQ_EN
  localparam int IRQ_EXP = 1;
`else
  localparam int IRQ_EXP = 0;
`endif

  logic               clk = 1'b0;
  logic               wb_rst_i;
  logic               start_i, step_valid_i, last_step_i;
  logic [NUM_OUT-1:0] spike_vec_i;
  logic [IDX_W-1:0]   cnt_sel_i;
  logic [CNT_W-1:0]   cnt_o, max_count_o;
  logic               busy_o, result_valid_o, irq_o;
  logic [IDX_W-1:0]   class_o;

  snn_spike_classifier #(.NUM_OUT(NUM_OUT), .CNT_W(CNT_W), .IDX_W(IDX_W)) dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i), .start_i(start_i), .step_valid_i(step_valid_i),
    .last_step_i(last_step_i), .spike_vec_i(spike_vec_i), .cnt_sel_i(cnt_sel_i),
    .cnt_o(cnt_o), .busy_o(busy_o), .result_valid_o(result_valid_o), .class_o(class_o),
    .max_count_o(max_count_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  bit cmp_en   = 0;

  // Model: phase 0 idle, 1 accumulating, 2 waiting for result, 3 result held
  int m_cnt [NUM_OUT];
  int m_phase, m_timer, m_class, m_max, m_fin_class, m_fin_max, m_irq;
  logic [3:0] sel_hold;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NUM_OUT; k++) m_cnt[k] = 0;
    m_phase = 0; m_timer = 0; m_class = 0; m_max = 0; m_irq = 0;
  endtask

  task automatic model_step();
    m_irq = 0;
    if (start_i) begin
      for (int k = 0; k < NUM_OUT; k++) m_cnt[k] = 0;
      m_phase = 1; m_class = 0; m_max = 0;
    end else if (m_phase == 1) begin
      if (step_valid_i) begin
        for (int k = 0; k < NUM_OUT; k++)
          if (spike_vec_i[k] && m_cnt[k] < CMAX) m_cnt[k]++;
        if (last_step_i) begin
          m_phase = 2;
          m_timer = NUM_OUT + 1;
          m_fin_class = 0; m_fin_max = 0;
          for (int k = 0; k < NUM_OUT; k++)
            if (m_cnt[k] > m_fin_max) begin m_fin_class = k; m_fin_max = m_cnt[k]; end
        end
      end
    end else if (m_phase == 2) begin
      m_timer--;
      if (m_timer == 0) begin
        m_phase = 3; m_class = m_fin_class; m_max = m_fin_max; m_irq = IRQ_EXP;
      end
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en && wb_rst_i === 1'b1) begin
      int sel;
      sel = int'(cnt_sel_i);
      chk("busy", int'(busy_o), int'(m_phase == 1 || m_phase == 2));
      chk("result_valid", int'(result_valid_o), int'(m_phase == 3));
      chk("cnt_o", int'(cnt_o), (sel < NUM_OUT) ? m_cnt[sel] : 0);
      chk("irq", int'(irq_o), m_irq);
      if (m_phase != 2) begin
        chk("class", int'(class_o), m_class);
        chk("max_count", int'(max_count_o), m_max);
      end
    end
  end

  task automatic cyc(input logic st, input logic sv, input logic ls,
                     input logic [NUM_OUT-1:0] v, input logic [3:0] sel);
    start_i = st; step_valid_i = sv; last_step_i = ls; spike_vec_i = v; cnt_sel_i = sel;
    @(posedge clk);
    model_step();
    #2;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, '0, sel_hold);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (result_valid_o !== 1'b1 && n < 40) begin
      idle();
      n++;
    end
    if (result_valid_o !== 1'b1) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int n;
    logic [NUM_OUT-1:0] v;
    wb_rst_i = 1'b0; start_i = 0; step_valid_i = 0; last_step_i = 0;
    spike_vec_i = '0; cnt_sel_i = '0; sel_hold = 4'd3;
    model_reset();
    #3;
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_valid", int'(result_valid_o), 0);
    chk("rst_class", int'(class_o), 0);
    chk("rst_max", int'(max_count_o), 0);
    chk("rst_irq", int'(irq_o), 0);
    #9 wb_rst_i = 1'b1;
    cmp_en = 1;

    // Steps before any start must be ignored
    repeat (3) cyc(1'b0, 1'b1, 1'b1, '1, 4'd0);

    // Single active neuron 3, five steps
    cyc(1'b1, 1'b0, 1'b0, '0, 4'd3);
    repeat (4) cyc(1'b0, 1'b1, 1'b0, NUM_OUT'(10'h008), 4'd3);
    cyc(1'b0, 1'b1, 1'b1, NUM_OUT'(10'h008), 4'd3);
    sel_hold = 4'd3;
    wait_done(n);
    chk("latency", n, 11);
    chk("s1_class", int'(class_o), 3);
    chk("s1_max", int'(max_count_o), 5);
    chk("s1_cnt3", int'(cnt_o), 5);
    chk("s1_irq_first", int'(irq_o), IRQ_EXP);
    cyc(1'b0, 1'b1, 1'b1, '1, 4'd3);
    chk("s1_irq_second", int'(irq_o), 0);
    chk("s1_hold_valid", int'(result_valid_o), 1);
    chk("s1_hold_cnt3", int'(cnt_o), 5);

    // Tie between neurons 2 and 7
    cyc(1'b1, 1'b0, 1'b0, '0, 4'd7);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, i == 3, NUM_OUT'(10'h084), 4'd7);
    sel_hold = 4'd7;
    wait_done(n);
    chk("tie_class", int'(class_o), 2);
    chk("tie_max", int'(max_count_o), 4);
    chk("tie_cnt7", int'(cnt_o), 4);

    // Saturation of counter 0
    cyc(1'b1, 1'b0, 1'b0, '0, 4'd0);
    for (int i = 0; i < 300; i++) cyc(1'b0, 1'b1, i == 299, NUM_OUT'(10'h001), 4'd0);
    sel_hold = 4'd0;
    wait_done(n);
    chk("sat_cnt0", int'(cnt_o), 255);
    chk("sat_class", int'(class_o), 0);
    chk("sat_max", int'(max_count_o), 255);

    // Restart in the middle of the scan
    cyc(1'b1, 1'b0, 1'b0, '0, 4'd0);
    repeat (6) cyc(1'b0, 1'b1, 1'b0, NUM_OUT'(10'h0ff), 4'd0);
    cyc(1'b0, 1'b1, 1'b1, NUM_OUT'(10'h0ff), 4'd0);
    repeat (4) idle();
    chk("mid_scan_busy", int'(busy_o), 1);
    cyc(1'b1, 1'b1, 1'b0, '1, 4'd0);
    cyc(1'b0, 1'b1, 1'b0, NUM_OUT'(10'h200), 4'd0);
    cyc(1'b0, 1'b1, 1'b1, NUM_OUT'(10'h200), 4'd0);
    wait_done(n);
    chk("restart_latency", n, 11);
    chk("restart_class", int'(class_o), 9);
    chk("restart_max", int'(max_count_o), 2);
    chk("restart_cnt0", int'(cnt_o), 0);

    // Asynchronous reset in the middle of accumulation
    cyc(1'b1, 1'b0, 1'b0, '0, 4'd5);
    repeat (3) cyc(1'b0, 1'b1, 1'b0, '1, 4'd5);
    chk("pre_rst_cnt5", int'(cnt_o), 3);
    wb_rst_i = 1'b0;
    #1;
    chk("arst_busy", int'(busy_o), 0);
    chk("arst_valid", int'(result_valid_o), 0);
    chk("arst_class", int'(class_o), 0);
    chk("arst_max", int'(max_count_o), 0);
    chk("arst_irq", int'(irq_o), 0);
    chk("arst_cnt5", int'(cnt_o), 0);
    model_reset();
    #1 wb_rst_i = 1'b1;
    repeat (5) cyc(1'b0, 1'b1, 1'b1, '1, 4'd5);
    chk("post_rst_idle", int'(busy_o), 0);

    // Randomized traffic checked by the model
    for (int i = 0; i < 4000; i++) begin
      logic st;
      st = ($urandom_range(0, 39) == 0) ||
           ((m_phase == 0 || m_phase == 3) && $urandom_range(0, 5) == 0);
      v = NUM_OUT'($urandom);
      cyc(st, $urandom_range(0, 9) < 6, $urandom_range(0, 11) == 0, v,
          4'($urandom_range(0, 15)));
    end

    idle();
    cmp_en = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/snn_spike_classifier.md
SNN_SPIKE_CLASSIFIER -- requirements
Module: snn_spike_classifier

Interface
REQ-001 SHALL provide parameter NUM_OUT, default 10, meaning the number of output-layer neurons whose spikes are classified.
REQ-002 SHALL provide parameter CNT_W, default 8, meaning the width of each per-neuron spike counter.
REQ-003 SHALL provide parameter IDX_W, default 4, meaning the width of the class index and must satisfy 2^IDX_W >= NUM_OUT.
REQ-004 SHALL have one clock and an asynchronous, active-low reset; ports wb_clk_i and wb_rst_i follow.
REQ-005 wb_clk_i  input  1  system clock; all state updates on its rising edge.
REQ-006 wb_rst_i  input  1  asynchronous active-low reset.
REQ-007 start_i  input  1  single-cycle pulse that begins a new inference.
REQ-008 step_valid_i  input  1  spike_vec_i holds one timestep of output spikes.
REQ-009 last_step_i  input  1  qualified by step_valid_i; marks the final timestep.
REQ-010 spike_vec_i  input  NUM_OUT  output-layer spike bits, where bit k is neuron k.
REQ-011 cnt_sel_i  input  IDX_W  counter readback select.
REQ-012 cnt_o  output  CNT_W  counter[cnt_sel_i], driven combinationally; 0 when cnt_sel_i >= NUM_OUT.
REQ-013 busy_o  output  1  high in ACCUM or SCAN.
REQ-014 result_valid_o  output  1  high in DONE.
REQ-015 class_o  output  IDX_W  winning neuron index.
REQ-016 max_count_o  output  CNT_W  spike count of the winning neuron.
REQ-017 irq_o  output  1  result-ready pulse (see Configuration).

Function
REQ-018 SHALL implement FSM states IDLE, ACCUM, SCAN, DONE.
REQ-019 When start_i is high in any state, the block SHALL clear all counters, class_o and max_count_o, and enter ACCUM on the next edge; this includes restart mid-ACCUM and mid-SCAN.
REQ-020 In ACCUM, each cycle with step_valid_i=1 SHALL increment counter[k] for every k with spike_vec_i[k]=1.
REQ-021 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-022 step_valid_i=1 with last_step_i=1 in ACCUM SHALL count that step and enter SCAN on the same edge.
REQ-023 step_valid_i SHALL be ignored in IDLE, SCAN and DONE; last_step_i without step_valid_i SHALL be ignored.
REQ-024 SCAN SHALL visit index 0..NUM_OUT-1, one index per cycle, keeping best index and best count; a later index replaces the best only if its count is strictly greater, so ties resolve to the lowest index.
REQ-025 After visiting index NUM_OUT-1, the FSM SHALL enter DONE, so result_valid_o rises exactly NUM_OUT+1 cycles after the last-step accept edge.
REQ-026 If all counts are 0, the block SHALL report class_o=0 and max_count_o=0.
REQ-027 DONE SHALL hold class_o, max_count_o and the counters stable until the next start_i.
REQ-028 start_i coincident with step_valid_i SHALL take priority, and that step SHALL NOT be counted.

Reset
REQ-029 Reset assertion SHALL immediately force IDLE, all counters 0, busy_o=0, result_valid_o=0, class_o=0, max_count_o=0 and irq_o=0, regardless of the clock.
REQ-030 After reset deasserts, the block SHALL stay in IDLE until start_i.

Configuration
REQ-031 With macro SNN_CLASSIFIER_IRQ_EN defined, irq_o SHALL pulse high for exactly one cycle, on the first DONE cycle of each inference.
REQ-032 Without SNN_CLASSIFIER_IRQ_EN, the irq_o port SHALL remain and be tied to 0, and no IRQ logic SHALL be synthesized.

Verification
REQ-033 Scenario: start, then 5 steps with spike_vec=0x008 and the last flagged -> result_valid_o 11 cycles after the last step; class_o=3; max_count_o=5; cnt_o(sel=3)=5.
REQ-034 Scenario: neurons 2 and 7 each spike 4 times, with no others spiking -> class_o=2 (tie goes to the lowest index); max_count_o=4.
REQ-035 Scenario: 300 steps with spike_vec=0x001 and CNT_W=8 -> counter[0]=255 (saturated); class_o=0; max_count_o=255.
REQ-036 Scenario: start_i asserted mid-SCAN, followed by 2 steps with spike_vec=0x200 -> previous counts cleared; class_o=9; max_count_o=2.
REQ-037 Scenario: wb_rst_i pulled low mid-ACCUM between clock edges -> all outputs 0 immediately, IDLE state, and step_valid_i ignored until start_i.
REQ-038 Scenario: with SNN_CLASSIFIER_IRQ_EN defined, one full inference -> irq_o high for exactly one cycle, coincident with result_valid_o rising; without the macro, irq_o stays 0.
